// File: rtl/uart_pkg.sv
// Shared types and constants for the UART autobaud slice.
package uart_pkg;

    typedef enum logic [2:0] {
        AB_IDLE = 3'd0,
        AB_ARM  = 3'd1,
        AB_WAIT = 3'd2,
        AB_MEAS = 3'd3,
        AB_CALC = 3'd4,
        AB_ERR  = 3'd5
    } ab_state_t;

    localparam int unsigned SYNC_EDGES = 4;
    localparam int unsigned FRA_BITS   = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// RX input conditioning: 2-flop synchronizer, optional glitch filter, falling-edge pulse.
// Optional filter enabled by `UART_AUTOBAUD_GLITCH_FILTER_EN.
module uart_rx_sync #(
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic rx_s,
    output logic fall_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic rx_prev;

    if (GLITCH_CYCLES < 1) begin : g_bad_glitch
        $error("GLITCH_CYCLES must be at least 1");
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= i_rx;
            sync_q2 <= sync_q1;
        end
    end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);

    logic [GW-1:0] run_cnt;
    logic          filt_q;

    // Output follows the synced line only after GLITCH_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_q  <= 1'b1;
            run_cnt <= '0;
        end else if (sync_q2 == filt_q) begin
            run_cnt <= '0;
        end else if (run_cnt == GW'(GLITCH_CYCLES - 1)) begin
            filt_q  <= sync_q2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign rx_s = filt_q;
`else
    assign rx_s = sync_q2;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    assign fall_pulse = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud controller: measures a 0x55 sync character and programs uart_baudgen divisor/fraction.
// Optional RX glitch filter enabled by `UART_AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH   = 20,
    parameter int unsigned DEFAULT_DIVISOR = 27,
    parameter int unsigned DEFAULT_FRA     = 8,
    parameter int unsigned MIN_DIVISOR     = 2,
    parameter int unsigned GLITCH_CYCLES   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    input  logic        i_start,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_divisor,
    output logic [3:0]  o_fra_adj
);

    localparam int unsigned CW = COUNTER_WIDTH;
    localparam int unsigned EW = $clog2(SYNC_EDGES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    if (COUNTER_WIDTH < 8 || COUNTER_WIDTH > 23) begin : g_bad_width
        $error("COUNTER_WIDTH must be within 8..23");
    end

    ab_state_t       state;
    logic [CW-1:0]   count;
    logic [EW-1:0]   edge_cnt;
    logic            calc_ok;
    logic            rx_s;
    logic            fall_pulse;
    logic [CW:0]     n_meas;
    logic [CW:0]     r_val;
    logic [CW:0]     div_full;
    logic            div_ok;

    uart_rx_sync #(
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_rx_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .rx_s       (rx_s),
        .fall_pulse (fall_pulse)
    );

    // Divisor is derived from the count value CALC will hold, so results load on CALC entry
    // and o_done coincides with the single CALC cycle.
    always_comb begin
        n_meas   = {1'b0, count} + 1'b1;
        r_val    = (n_meas + (CW+1)'(4)) >> 3;
        div_full = r_val >> FRA_BITS;
        div_ok   = (div_full >= (CW+1)'(MIN_DIVISOR));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= AB_IDLE;
            count     <= '0;
            edge_cnt  <= '0;
            calc_ok   <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_divisor <= 16'(DEFAULT_DIVISOR);
            o_fra_adj <= 4'(DEFAULT_FRA);
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            if (i_abort) begin
                state <= AB_IDLE;
            end else begin
                case (state)
                    AB_IDLE: if (i_start) state <= AB_ARM;
                    AB_ARM:  if (rx_s) state <= AB_WAIT;
                    AB_WAIT: begin
                        if (fall_pulse) begin
                            state    <= AB_MEAS;
                            count    <= '0;
                            edge_cnt <= '0;
                        end
                    end
                    AB_MEAS: begin
                        count <= count + 1'b1;
                        if (count == CNT_MAX) begin
                            state   <= AB_ERR;
                            o_error <= 1'b1;
                        end else if (fall_pulse) begin
                            if (edge_cnt == EW'(SYNC_EDGES - 1)) begin
                                state   <= AB_CALC;
                                calc_ok <= div_ok;
                                if (div_ok) begin
                                    o_divisor <= 16'(div_full);
                                    o_fra_adj <= r_val[FRA_BITS-1:0];
                                    o_done    <= 1'b1;
                                end
                            end else begin
                                edge_cnt <= edge_cnt + 1'b1;
                            end
                        end
                    end
                    AB_CALC: begin
                        if (calc_ok) begin
                            state <= AB_IDLE;
                        end else begin
                            state   <= AB_ERR;
                            o_error <= 1'b1;
                        end
                    end
                    AB_ERR:  state <= AB_IDLE;
                    default: state <= AB_IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state != AB_IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: 0x55 waveforms at chosen/random bit lengths vs arithmetic model.
module tb_uart_autobaud;

    localparam int CW = 15;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    localparam int LAT = 7;
    localparam bit FILTER = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit FILTER = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_divisor;
    logic [3:0]  o_fra_adj;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_div;
    logic [3:0]  exp_fra;

    uart_autobaud #(
        .COUNTER_WIDTH   (CW),
        .DEFAULT_DIVISOR (27),
        .DEFAULT_FRA     (8),
        .MIN_DIVISOR     (2),
        .GLITCH_CYCLES   (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_divisor (o_divisor),
        .o_fra_adj (o_fra_adj)
    );

    always #20 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_error === 1'b1) err_cnt++;
    end

    // Reference: 8 bit periods rounded to 1/16 of a divisor step.
    function automatic void model(input int n, output bit ok, output logic [15:0] d, output logic [3:0] f);
        int r;
        r  = (n + 4) / 8;
        d  = 16'(r / 16);
        f  = 4'(r % 16);
        ok = (r / 16) >= 2;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Drive 0x55 LSB-first where bit i starts at cycle i*n/8, so falls at bit 0 and bit 8 are n apart.
    task automatic send_55(input int n, input bit timed, input bit exp_ok);
        int t[10];
        int seg;
        for (int i = 0; i < 10; i++) t[i] = i * n / 8;
        for (int i = 0; i < 9; i++) begin
            i_rx = (i % 2 == 1);
            seg  = t[i+1] - t[i];
            if (i == 8 && timed) begin
                repeat (LAT) @(posedge i_clk);
                @(negedge i_clk);
                vectors++;
                if (o_done !== exp_ok) begin
                    miscompares++;
                    $display("FAIL done_timing n=%0d: got %b expected %b", n, o_done, exp_ok);
                end
                @(posedge i_clk);
                @(negedge i_clk);
                vectors++;
                if (o_error !== !exp_ok) begin
                    miscompares++;
                    $display("FAIL error_timing n=%0d: got %b expected %b", n, o_error, !exp_ok);
                end
                repeat (seg - LAT - 1) @(posedge i_clk);
                #1;
            end else begin
                repeat (seg) @(posedge i_clk);
                #1;
            end
        end
        i_rx = 1'b1;
        repeat (40) tick();
    endtask

    task automatic check_outputs(input string name, input int d0, input int e0, input int dn, input int en);
        @(negedge i_clk);
        vectors++;
        if (o_divisor !== exp_div) begin
            miscompares++;
            $display("FAIL %s divisor: got %0d expected %0d", name, o_divisor, exp_div);
        end
        vectors++;
        if (o_fra_adj !== exp_fra) begin
            miscompares++;
            $display("FAIL %s fra_adj: got %0d expected %0d", name, o_fra_adj, exp_fra);
        end
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: got %b expected 0", name, o_busy);
        end
        vectors++;
        if (done_cnt - d0 !== dn) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d expected %0d", name, done_cnt - d0, dn);
        end
        vectors++;
        if (err_cnt - e0 !== en) begin
            miscompares++;
            $display("FAIL %s error_pulses: got %0d expected %0d", name, err_cnt - e0, en);
        end
    endtask

    task automatic test_measure(input string name, input int n);
        bit ok;
        logic [15:0] d;
        logic [3:0] f;
        int d0, e0;
        model(n, ok, d, f);
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        send_55(n, 1'b1, ok);
        if (ok) begin
            exp_div = d;
            exp_fra = f;
        end
        check_outputs(name, d0, e0, ok ? 1 : 0, ok ? 0 : 1);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        exp_div = 16'd27;
        exp_fra = 4'd8;
        @(negedge i_clk);
        vectors++;
        if (o_done !== 1'b0 || o_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got done=%b error=%b expected 0/0", o_done, o_error);
        end
        check_outputs("reset", done_cnt, err_cnt, 0, 0);
    endtask

    task automatic test_baud_115200();
        test_measure("baud_115200", 1736);
    endtask

    task automatic test_baud_9600();
        int period_x16;
        test_measure("baud_9600", 20833);
        // uart_baudgen divides by divisor + fra/16 on average: 162.75 clk = 2604/16.
        period_x16 = int'(o_divisor) * 16 + int'(o_fra_adj);
        vectors++;
        if (period_x16 !== 2604) begin
            miscompares++;
            $display("FAIL baudgen_period_x16: got %0d expected 2604", period_x16);
        end
    endtask

    task automatic test_overflow();
        int d0, e0, waited;
        bit seen;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        i_rx = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < (1 << CW) + 300) begin
            @(negedge i_clk);
            if (o_error === 1'b1) seen = 1'b1;
            waited++;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL overflow_error: got no pulse within %0d cycles expected pulse", waited);
        end
        vectors++;
        if (waited < (1 << CW)) begin
            miscompares++;
            $display("FAIL overflow_latency: got %0d cycles expected at least %0d", waited, 1 << CW);
        end
        @(posedge i_clk);
        #1 i_rx = 1'b1;
        repeat (20) tick();
        check_outputs("overflow", d0, e0, 0, 1);
    endtask

    task automatic test_min_divisor();
        test_measure("min_divisor", 128);
    endtask

    task automatic test_abort();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        i_rx = 1'b0; repeat (30) tick();
        i_rx = 1'b1; repeat (30) tick();
        i_rx = 1'b0; repeat (10) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b expected 0", o_busy);
        end
        for (int k = 0; k < 6; k++) begin
            i_rx = ~i_rx;
            repeat (30) tick();
        end
        i_rx = 1'b1;
        repeat (40) tick();
        check_outputs("abort", d0, e0, 0, 0);
    endtask

    task automatic test_start_while_busy();
        bit ok;
        logic [15:0] d;
        logic [3:0] f;
        int d0, e0, n;
        n = 1000;
        model(n, ok, d, f);
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        fork
            send_55(n, 1'b1, ok);
            begin
                repeat (400) @(posedge i_clk);
                #1 i_start = 1'b1;
                @(posedge i_clk);
                #1 i_start = 1'b0;
            end
        join
        exp_div = d;
        exp_fra = f;
        check_outputs("start_while_busy", d0, e0, 1, 0);
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(150, 2000));
            test_measure($sformatf("random_n%0d", n), n);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        logic [15:0] d;
        logic [3:0] f;
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        i_rx = 1'b0; repeat (2) tick();
        i_rx = 1'b1; repeat (20) tick();
        // Unfiltered, the glitch is the first fall and the sync's bit-6 fall becomes the 4th edge.
        n = FILTER ? 1736 : 22 + 6 * 1736 / 8;
        model(n, ok, d, f);
        send_55(1736, FILTER, 1'b1);
        exp_div = d;
        exp_fra = f;
        check_outputs("glitch", d0, e0, 1, 0);
    endtask

    task automatic test_async_reset();
        pulse_start();
        repeat (10) tick();
        i_rx = 1'b0;
        repeat (100) tick();
        #7 i_rst = 1'b1;
        #1;
        exp_div = 16'd27;
        exp_fra = 4'd8;
        vectors++;
        if (o_divisor !== exp_div || o_fra_adj !== exp_fra || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got div=%0d fra=%0d busy=%b expected 27/8/0",
                     o_divisor, o_fra_adj, o_busy);
        end
        i_rx = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (5) tick();
        check_outputs("after_reset", done_cnt, err_cnt, 0, 0);
    endtask

    initial begin
        test_reset();
        test_baud_115200();
        test_baud_9600();
        test_overflow();
        test_min_divisor();
        test_abort();
        test_start_while_busy();
        test_random();
        test_glitch();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
